// File: rtl/multi_accum_array.sv
// NCH independent W-bit accumulators with per-channel 3-bit commands,
// two-stage pipeline, sticky overflow flags and a sticky global halt.
module multi_accum_array #(
  parameter int NCH = 2,
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   cmd_vld,
  input  logic [3*NCH-1:0] opcode,
  input  logic [W*NCH-1:0] operand,
  output logic [W*NCH-1:0] accum_out,
  output logic [NCH-1:0]   ovf,
  output logic             halt
);

  typedef enum logic [2:0] {
    OP_NOP, OP_INC, OP_DEC, OP_ADD,
    OP_CPY, OP_LD,  OP_CLR, OP_HLT
  } op_e;

  localparam logic [W-1:0] ONES = '1;

  logic [NCH-1:0]   vld_q;
  logic [3*NCH-1:0] op_q;
  logic [W*NCH-1:0] opd_q;
  logic [W-1:0]     acc_q [NCH];
  logic [W-1:0]     acc_d [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [NCH-1:0]   ovf_set;
  logic [NCH-1:0]   hreq;
  logic             halt_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    op_e          op;
    logic [W-1:0] opd;
    logic [W-1:0] cur;
    logic [W-1:0] src;
    logic [W-1:0] nxt;
    logic [W:0]   sum;
    logic         set;
    logic         hr;

    assign op  = op_e'(op_q[3*g +: 3]);
    assign opd = opd_q[W*g +: W];
    assign cur = acc_q[g];

    // Out-of-range or oversized source index falls back to self.
    always_comb begin
      src = cur;
      for (int j = 0; j < NCH; j++)
        if (opd == W'(j)) src = acc_q[j];
    end

    always_comb begin
      nxt = cur;
      set = 1'b0;
      hr  = 1'b0;
      sum = '0;
      if (vld_q[g] && !halt_q) begin
        unique case (op)
          OP_NOP: ;
          OP_INC: begin
            sum = {1'b0, cur} + (W+1)'(1);
            set = sum[W];
            nxt = (set && SAT != 0) ? ONES : sum[W-1:0];
          end
          OP_DEC: begin
            set = (cur == '0);
            nxt = (set && SAT != 0) ? '0 : cur - W'(1);
          end
          OP_ADD: begin
            sum = {1'b0, cur} + {1'b0, opd};
            set = sum[W];
            nxt = (set && SAT != 0) ? ONES : sum[W-1:0];
          end
          OP_CPY: nxt = src;
          OP_LD:  nxt = opd;
          OP_CLR: nxt = '0;
          OP_HLT: hr  = 1'b1;
          default: ;
        endcase
      end
    end

    assign acc_d[g]   = nxt;
    assign ovf_set[g] = set;
    assign hreq[g]    = hr;
    assign accum_out[W*g +: W] = acc_q[g];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q  <= '0;
      op_q   <= '0;
      opd_q  <= '0;
      ovf_q  <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
    end else begin
      vld_q  <= cmd_vld;
      op_q   <= opcode;
      opd_q  <= operand;
      ovf_q  <= ovf_q | ovf_set;
      halt_q <= halt_q | (|hreq);
      for (int i = 0; i < NCH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign ovf  = ovf_q;
  assign halt = halt_q;

endmodule

// File: tb/tb_multi_accum_array.sv
// Scoreboard bench for multi_accum_array: wrap and saturate instances
// share one directed stimulus stream.
module tb_multi_accum_array;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  cmd_vld;
  logic [5:0]  opcode;
  logic [15:0] operand;
  logic [15:0] acc0, acc1;
  logic [1:0]  ovf0, ovf1;
  logic        halt0, halt1;

  always #5 clk = ~clk;

  multi_accum_array #(.NCH(2), .W(8), .SAT(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .cmd_vld(cmd_vld),
    .opcode(opcode), .operand(operand),
    .accum_out(acc0), .ovf(ovf0), .halt(halt0)
  );

  multi_accum_array #(.NCH(2), .W(8), .SAT(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .cmd_vld(cmd_vld),
    .opcode(opcode), .operand(operand),
    .accum_out(acc1), .ovf(ovf1), .halt(halt1)
  );

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, DEC = 3'd2, ADD = 3'd3;
  localparam logic [2:0] CPY = 3'd4, LD  = 3'd5, CLR = 3'd6, HLT = 3'd7;

  typedef struct {
    int          cyc;
    logic [15:0] a0;
    logic [1:0]  f0;
    logic [15:0] a1;
    logic [1:0]  f1;
    logic        h;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int dt, input logic [15:0] a0,
                      input logic [1:0] f0, input logic [15:0] a1,
                      input logic [1:0] f1, input logic h);
    exp_t x;
    x.cyc = cyc + dt;
    x.a0 = a0; x.f0 = f0; x.a1 = a1; x.f1 = f1; x.h = h;
    q.push_back(x);
  endtask

  task automatic cmd(input logic [1:0] v, input logic [2:0] o0,
                     input logic [7:0] d0, input logic [2:0] o1,
                     input logic [7:0] d1);
    cmd_vld = v;
    opcode  = {o1, o0};
    operand = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cmd(2'b00, NOP, 8'h00, NOP, 8'h00);
  endtask

  // Monitor: pops every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed cyc=%0d", e.cyc);
      end else begin
        n_cmp++;
        if ({acc0, ovf0, halt0} !== {e.a0, e.f0, e.h}) begin
          n_bad++;
          $display("FAIL wrap cyc=%0d got acc=%h ovf=%b halt=%b exp acc=%h ovf=%b halt=%b",
                   cyc, acc0, ovf0, halt0, e.a0, e.f0, e.h);
        end
        n_cmp++;
        if ({acc1, ovf1, halt1} !== {e.a1, e.f1, e.h}) begin
          n_bad++;
          $display("FAIL sat cyc=%0d got acc=%h ovf=%b halt=%b exp acc=%h ovf=%b halt=%b",
                   cyc, acc1, ovf1, halt1, e.a1, e.f1, e.h);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    cmd_vld = '0;
    opcode  = '0;
    operand = '0;
    repeat (2) @(posedge clk);
    #1;
    push(0, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0);
    reset_n = 1'b1;

    // incr x3 on ch0, then a command with valid low
    push(2, 16'h0001, 2'b00, 16'h0001, 2'b00, 1'b0);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h0002, 2'b00, 16'h0002, 2'b00, 1'b0);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h0003, 2'b00, 16'h0003, 2'b00, 1'b0);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h0003, 2'b00, 16'h0003, 2'b00, 1'b0);
    cmd(2'b00, INC, 8'h00, INC, 8'h00);
    idle(2);

    // load FE, incr, incr, clear
    push(2, 16'h00FE, 2'b00, 16'h00FE, 2'b00, 1'b0);
    cmd(2'b01, LD, 8'hFE, NOP, 8'h00);
    push(2, 16'h00FF, 2'b00, 16'h00FF, 2'b00, 1'b0);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h0000, 2'b01, 16'h00FF, 2'b01, 1'b0);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h0000, 2'b01, 16'h0000, 2'b01, 1'b0);
    cmd(2'b01, CLR, 8'h00, NOP, 8'h00);
    idle(2);

    // swap, invalid copies, chained copy
    push(2, 16'h0905, 2'b01, 16'h0905, 2'b01, 1'b0);
    cmd(2'b11, LD, 8'h05, LD, 8'h09);
    push(2, 16'h0509, 2'b01, 16'h0509, 2'b01, 1'b0);
    cmd(2'b11, CPY, 8'h01, CPY, 8'h00);
    push(2, 16'h0509, 2'b01, 16'h0509, 2'b01, 1'b0);
    cmd(2'b11, CPY, 8'h02, CPY, 8'h10);
    push(2, 16'h0507, 2'b01, 16'h0507, 2'b01, 1'b0);
    cmd(2'b01, LD, 8'h07, NOP, 8'h00);
    push(2, 16'h0707, 2'b01, 16'h0707, 2'b01, 1'b0);
    cmd(2'b10, NOP, 8'h00, CPY, 8'h00);
    idle(2);

    // add overflow, decr at zero, plain add
    push(2, 16'hF000, 2'b01, 16'hF000, 2'b01, 1'b0);
    cmd(2'b11, LD, 8'h00, LD, 8'hF0);
    push(2, 16'h10FF, 2'b11, 16'hFF00, 2'b11, 1'b0);
    cmd(2'b11, DEC, 8'h00, ADD, 8'h20);
    push(2, 16'h3000, 2'b11, 16'h3000, 2'b11, 1'b0);
    cmd(2'b11, CLR, 8'h00, LD, 8'h30);
    push(2, 16'h707E, 2'b11, 16'h707E, 2'b11, 1'b0);
    cmd(2'b11, ADD, 8'h7E, ADD, 8'h40);
    idle(2);

    // halt on ch1 with incr on ch0 at t and t+1
    push(1, 16'h707E, 2'b11, 16'h707E, 2'b11, 1'b0);
    push(2, 16'h707F, 2'b11, 16'h707F, 2'b11, 1'b1);
    cmd(2'b11, INC, 8'h00, HLT, 8'h00);
    push(2, 16'h707F, 2'b11, 16'h707F, 2'b11, 1'b1);
    cmd(2'b01, INC, 8'h00, NOP, 8'h00);
    push(2, 16'h707F, 2'b11, 16'h707F, 2'b11, 1'b1);
    cmd(2'b11, LD, 8'h55, LD, 8'h55);
    idle(1);

    // reset, restart counting, then a mid-stream reset
    reset_n = 1'b0;
    push(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    reset_n = 1'b1;
    push(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0);
    push(2, 16'h0101, 2'b00, 16'h0101, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    push(2, 16'h0202, 2'b00, 16'h0202, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    reset_n = 1'b0;
    push(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    reset_n = 1'b1;
    push(1, 16'h0000, 2'b00, 16'h0000, 2'b00, 1'b0);
    push(2, 16'h0101, 2'b00, 16'h0101, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    push(2, 16'h0202, 2'b00, 16'h0202, 2'b00, 1'b0);
    cmd(2'b11, INC, 8'h00, INC, 8'h00);
    idle(3);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
